glitc_realign_sequencer: RTL and testbench

- Performs word alignment of the deserialized channel data that the control registers request.
- Consumes the one-cycle realign request and steps each channel's ISERDES bitslip until a training pattern is received consistently.
- Returns the one-cycle realigned pulse to the control register block (sets its status bit) and reports a per-channel lock mask.
- Sits between the control registers and the per-channel ISERDES front end, in the user_clk_i domain.

---
 rtl/glitc_realign_pkg.sv | 12 +
 rtl/glitc_chan_mux.sv | 22 ++
 rtl/glitc_realign_sequencer.sv | 115 +++++++++++
 tb/tb_glitc_realign_sequencer.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/glitc_realign_pkg.sv
// glitc_realign_pkg: shared state encoding, default constants and clog2 helper
package glitc_realign_pkg;
   typedef enum logic [2:0] {ST_IDLE, ST_SETTLE, ST_COMPARE, ST_SLIP, ST_NEXT, ST_DONE} state_e;
   localparam logic [7:0] TRAIN_DEF = 8'hA5;
   localparam int SETTLE_DEF = 8;
   localparam int MATCH_DEF = 16;
   function automatic int clog2(input int v);
      int r = 0;
      for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
      return r;
   endfunction
endpackage

// File: rtl/glitc_chan_mux.sv
// glitc_chan_mux: registers the selected channel word; match_o flags it equals TRAIN
//   user_clk_i/user_rst_i  clock, async active-high reset
//   data_i   NCH packed words     ch_i  channel select
//   match_o  registered word == TRAIN, one cycle behind ch_i/data_i
module glitc_chan_mux #(
   parameter int NCH = 4,
   parameter int WIDTH = 8,
   parameter int CW = 2,
   parameter logic [WIDTH-1:0] TRAIN = '0
) (
   input  logic                   user_clk_i,
   input  logic                   user_rst_i,
   input  logic [NCH*WIDTH-1:0]   data_i,
   input  logic [CW-1:0]          ch_i,
   output logic                   match_o
);
   logic [WIDTH-1:0] word_q;
   always_ff @(posedge user_clk_i or posedge user_rst_i)
      if (user_rst_i) word_q <= '0;
      else word_q <= data_i[ch_i*WIDTH +: WIDTH];
   assign match_o = word_q == TRAIN;
endmodule

// File: rtl/glitc_realign_sequencer.sv
// glitc_realign_sequencer: steps each channel's ISERDES bitslip until TRAIN is seen MATCH times in a row
//   user_clk_i/user_rst_i  clock, async active-high reset
//   realign_i    one-cycle start request       data_i       NCH words, channel n at [n*WIDTH +: WIDTH]
//   bitslip_o    one-cycle slip per channel    realigned_o  one-cycle completion pulse
//   busy_o       sequence running              locked_o     per-channel lock of last sequence
//   fail_o       some channel failed in last sequence
//   GLITC_REALIGN_ERRCNT_EN adds err_clear_i and err_count_o, a saturating IDLE-time mismatch counter
module glitc_realign_sequencer
   import glitc_realign_pkg::*;
#(
   parameter int NCH = 4,
   parameter int WIDTH = 8,
   parameter logic [WIDTH-1:0] TRAIN = WIDTH'(TRAIN_DEF),
   parameter int SETTLE = SETTLE_DEF,
   parameter int MATCH = MATCH_DEF
) (
   input  logic                   user_clk_i,
   input  logic                   user_rst_i,
`ifdef GLITC_REALIGN_ERRCNT_EN
   input  logic                   err_clear_i,
   output logic [15:0]            err_count_o,
`endif
   input  logic                   realign_i,
   input  logic [NCH*WIDTH-1:0]   data_i,
   output logic [NCH-1:0]         bitslip_o,
   output logic                   realigned_o,
   output logic                   busy_o,
   output logic [NCH-1:0]         locked_o,
   output logic                   fail_o
);
   localparam int CW = clog2(NCH) > 0 ? clog2(NCH) : 1;
   localparam int SW = clog2(WIDTH) > 0 ? clog2(WIDTH) : 1;
   state_e state_q;
   logic [CW-1:0] ch_q;
   logic [SW-1:0] slips_q;
   logic [7:0] scnt_q, mcnt_q;
   logic match;
   glitc_chan_mux #(.NCH(NCH), .WIDTH(WIDTH), .CW(CW), .TRAIN(TRAIN)) u_mux (
      .user_clk_i(user_clk_i),
      .user_rst_i(user_rst_i),
      .data_i(data_i),
      .ch_i(ch_q),
      .match_o(match)
   );
   // ch_q is stable through SETTLE (>= 1 cycle), which hides the mux register latency
   always_ff @(posedge user_clk_i or posedge user_rst_i)
      if (user_rst_i) begin
         state_q <= ST_IDLE;
         ch_q <= '0;
         slips_q <= '0;
         scnt_q <= '0;
         mcnt_q <= '0;
         bitslip_o <= '0;
         realigned_o <= 1'b0;
         busy_o <= 1'b0;
         locked_o <= '0;
         fail_o <= 1'b0;
      end else begin
         bitslip_o <= '0;
         realigned_o <= 1'b0;
         case (state_q)
            ST_IDLE: if (realign_i) begin
               locked_o <= '0;
               fail_o <= 1'b0;
               ch_q <= '0;
               slips_q <= '0;
               scnt_q <= '0;
               busy_o <= 1'b1;
               state_q <= ST_SETTLE;
            end
            ST_SETTLE: if (scnt_q == 8'(SETTLE - 1)) begin
               scnt_q <= '0;
               mcnt_q <= '0;
               state_q <= ST_COMPARE;
            end else scnt_q <= scnt_q + 8'd1;
            ST_COMPARE: if (match) begin
               if (mcnt_q == 8'(MATCH - 1)) begin
                  locked_o[ch_q] <= 1'b1;
                  state_q <= ST_NEXT;
               end else mcnt_q <= mcnt_q + 8'd1;
            end else if (slips_q == SW'(WIDTH - 1)) begin
               fail_o <= 1'b1;
               state_q <= ST_NEXT;
            end else begin
               bitslip_o[ch_q] <= 1'b1;
               state_q <= ST_SLIP;
            end
            ST_SLIP: begin
               slips_q <= slips_q + 1'b1;
               state_q <= ST_SETTLE;
            end
            ST_NEXT: if (ch_q == CW'(NCH - 1)) begin
               busy_o <= 1'b0;
               realigned_o <= 1'b1;
               state_q <= ST_DONE;
            end else begin
               ch_q <= ch_q + 1'b1;
               slips_q <= '0;
               state_q <= ST_SETTLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
`ifdef GLITC_REALIGN_ERRCNT_EN
   logic any_err;
   always_comb begin
      any_err = 1'b0;
      for (int n = 0; n < NCH; n++) any_err = any_err | (data_i[n*WIDTH +: WIDTH] != TRAIN);
   end
   always_ff @(posedge user_clk_i or posedge user_rst_i)
      if (user_rst_i) err_count_o <= '0;
      else if (err_clear_i || (state_q == ST_IDLE && realign_i)) err_count_o <= '0;
      else if (state_q == ST_IDLE && !fail_o && &locked_o && any_err && !(&err_count_o)) err_count_o <= err_count_o + 16'd1;
`endif
endmodule

// File: tb/tb_glitc_realign_sequencer.sv
// tb_glitc_realign_sequencer: randomized bench with a rotating-ISERDES model and timing model
module tb_glitc_realign_sequencer;
   localparam int NCH = 4, W = 8, S = 8, M = 16;
   localparam logic [W-1:0] TR = 8'hA5;
   logic clk = 0, rst = 1, realign = 0, clr = 0;
   logic [NCH*W-1:0] data;
   logic [NCH-1:0] bitslip, locked;
   logic realigned, busy, fail;
`ifdef GLITC_REALIGN_ERRCNT_EN
   logic err_clear = 0, corrupt = 0;
   logic [15:0] err_count;
`endif
   int init_off [NCH];
   bit dead [NCH];
   int slips_seen [NCH];
   int last_slip [NCH];
   int cyc = 0, rl_cnt = 0, rl_cyc = 0, busy_low = 0, multi = 0, min_gap = 0;
   bit in_seq = 0;
   int pass_cnt = 0, total = 0, start = 0;

   glitc_realign_sequencer #(.NCH(NCH), .WIDTH(W), .TRAIN(TR), .SETTLE(S), .MATCH(M)) dut (
      .user_clk_i(clk),
      .user_rst_i(rst),
`ifdef GLITC_REALIGN_ERRCNT_EN
      .err_clear_i(err_clear),
      .err_count_o(err_count),
`endif
      .realign_i(realign),
      .data_i(data),
      .bitslip_o(bitslip),
      .realigned_o(realigned),
      .busy_o(busy),
      .locked_o(locked),
      .fail_o(fail)
   );

   always #5 clk = ~clk;

   function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input int k);
      logic [2*W-1:0] t;
      t = {x, x} << k;
      return t[2*W-1:W];
   endfunction

   // ISERDES model: channel word is TRAIN rotated by its offset; each bitslip rotates it back by one
   always_comb begin
      data = '0;
      for (int n = 0; n < NCH; n++)
         data[n*W +: W] = dead[n] ? '0 : rotl(TR, ((init_off[n] - slips_seen[n]) % W + W) % W);
`ifdef GLITC_REALIGN_ERRCNT_EN
      data[0] = data[0] ^ corrupt;
`endif
   end

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (clr) begin
         rl_cnt <= 0;
         busy_low <= 0;
         multi <= 0;
         min_gap <= 1 << 30;
         for (int n = 0; n < NCH; n++) begin
            slips_seen[n] <= 0;
            last_slip[n] <= -1000;
         end
      end else begin
         for (int n = 0; n < NCH; n++)
            if (bitslip[n]) begin
               slips_seen[n] <= slips_seen[n] + 1;
               last_slip[n] <= cyc + 1;
               if (cyc + 1 - last_slip[n] < min_gap) min_gap <= cyc + 1 - last_slip[n];
            end
         if ($countones(bitslip) > 1) multi <= multi + 1;
         if (realigned) begin
            rl_cnt <= rl_cnt + 1;
            rl_cyc <= cyc + 1;
         end
         if (in_seq && !busy && !realigned) busy_low <= busy_low + 1;
      end
   end

   function automatic int exp_slips(input int n);
      return dead[n] ? W - 1 : init_off[n];
   endfunction

   // cycles from the realign_i cycle through the realigned_o cycle, inclusive
   function automatic int exp_lat();
      int l = 2;
      for (int n = 0; n < NCH; n++) l += exp_slips(n) * (S + 2) + S + (dead[n] ? 1 : M) + 1;
      return l;
   endfunction

   function automatic logic [NCH-1:0] exp_locked();
      logic [NCH-1:0] r;
      for (int n = 0; n < NCH; n++) r[n] = !dead[n];
      return r;
   endfunction

   task automatic clear_cfg();
      for (int n = 0; n < NCH; n++) begin
         init_off[n] = 0;
         dead[n] = 0;
      end
   endtask

   task automatic run_seq(output int lat, output bit to);
      clr = 1;
      @(negedge clk); #1;
      clr = 0;
      @(posedge clk); #1;
      realign = 1;
      start = cyc + 1;
      @(posedge clk); #1;
      realign = 0;
      in_seq = 1;
      for (int i = 0; i < 5000 && rl_cnt == 0; i++) begin
         @(negedge clk); #1;
      end
      in_seq = 0;
      to = rl_cnt == 0;
      lat = rl_cyc - start + 1;
      repeat (30) @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_cfg();
      clr = 1;
      repeat (3) @(negedge clk);
      #1;
      total++; if (bitslip !== '0) $display("FAIL reset_bitslip: got %h want 0", bitslip); else pass_cnt++;
      total++; if (realigned !== 1'b0) $display("FAIL reset_realigned: got %b want 0", realigned); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total++; if (locked !== '0) $display("FAIL reset_locked: got %h want 0", locked); else pass_cnt++;
      total++; if (fail !== 1'b0) $display("FAIL reset_fail: got %b want 0", fail); else pass_cnt++;
      @(posedge clk); #1;
      rst = 0;
      clr = 0;
      repeat (10) @(negedge clk);
      #1;
      total++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else pass_cnt++;
      total++; if (rl_cnt != 0) $display("FAIL idle_realigned: got %0d pulses want 0", rl_cnt); else pass_cnt++;
   endtask

   task automatic test_aligned();
      int lat;
      bit to;
      clear_cfg();
      run_seq(lat, to);
      total++; if (to) $display("FAIL aligned_timeout: got no realigned_o want one"); else pass_cnt++;
      total++; if (lat != NCH * (S + M + 1) + 2) $display("FAIL aligned_latency: got %0d want %0d", lat, NCH * (S + M + 1) + 2); else pass_cnt++;
      total++; if (slips_seen[0] + slips_seen[1] + slips_seen[2] + slips_seen[3] != 0)
         $display("FAIL aligned_slips: got %0d want 0", slips_seen[0] + slips_seen[1] + slips_seen[2] + slips_seen[3]); else pass_cnt++;
      total++; if (locked !== 4'hF) $display("FAIL aligned_locked: got %h want f", locked); else pass_cnt++;
      total++; if (fail !== 1'b0) $display("FAIL aligned_fail: got %b want 0", fail); else pass_cnt++;
      total++; if (rl_cnt != 1) $display("FAIL aligned_pulses: got %0d want 1", rl_cnt); else pass_cnt++;
      total++; if (busy_low != 0) $display("FAIL aligned_busy_gap: got %0d low cycles want 0", busy_low); else pass_cnt++;
   endtask

   task automatic test_rotated();
      int lat;
      bit to;
      clear_cfg();
      init_off[2] = 3;
      run_seq(lat, to);
      total++; if (to) $display("FAIL rot_timeout: got no realigned_o want one"); else pass_cnt++;
      total++; if (slips_seen[2] != 3) $display("FAIL rot_slips2: got %0d want 3", slips_seen[2]); else pass_cnt++;
      total++; if (slips_seen[0] + slips_seen[1] + slips_seen[3] != 0)
         $display("FAIL rot_other_slips: got %0d want 0", slips_seen[0] + slips_seen[1] + slips_seen[3]); else pass_cnt++;
      total++; if (min_gap < S + 1) $display("FAIL rot_gap: got %0d want >= %0d", min_gap, S + 1); else pass_cnt++;
      total++; if (locked !== 4'hF) $display("FAIL rot_locked: got %h want f", locked); else pass_cnt++;
      total++; if (lat != exp_lat()) $display("FAIL rot_latency: got %0d want %0d", lat, exp_lat()); else pass_cnt++;
   endtask

   task automatic test_dead();
      int lat;
      bit to;
      clear_cfg();
      dead[1] = 1;
      run_seq(lat, to);
      total++; if (to) $display("FAIL dead_timeout: got no realigned_o want one"); else pass_cnt++;
      total++; if (slips_seen[1] != W - 1) $display("FAIL dead_slips1: got %0d want %0d", slips_seen[1], W - 1); else pass_cnt++;
      total++; if (locked !== 4'hD) $display("FAIL dead_locked: got %h want d", locked); else pass_cnt++;
      total++; if (fail !== 1'b1) $display("FAIL dead_fail: got %b want 1", fail); else pass_cnt++;
      total++; if (rl_cnt != 1) $display("FAIL dead_pulses: got %0d want 1", rl_cnt); else pass_cnt++;
      total++; if (lat != exp_lat()) $display("FAIL dead_latency: got %0d want %0d", lat, exp_lat()); else pass_cnt++;
   endtask

   task automatic test_ignore();
      int lat;
      clear_cfg();
      lat = exp_lat();
      clr = 1;
      @(negedge clk); #1;
      clr = 0;
      @(posedge clk); #1;
      realign = 1;
      start = cyc + 1;
      @(posedge clk); #1;
      realign = 0;
      in_seq = 1;
      while (cyc + 1 < start + 50) begin
         @(posedge clk); #1;
      end
      realign = 1;
      @(posedge clk); #1;
      realign = 0;
      while (cyc + 1 < start + lat - 1) begin
         @(posedge clk); #1;
      end
      realign = 1;
      @(posedge clk); #1;
      realign = 0;
      in_seq = 0;
      repeat (150) @(negedge clk);
      #1;
      total++; if (rl_cnt != 1) $display("FAIL ignore_pulses: got %0d want 1", rl_cnt); else pass_cnt++;
      total++; if (rl_cyc != start + lat - 1) $display("FAIL ignore_latency: got %0d want %0d", rl_cyc - start + 1, lat); else pass_cnt++;
      total++; if (busy_low != 0) $display("FAIL ignore_busy_gap: got %0d low cycles want 0", busy_low); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL ignore_busy_after: got %b want 0", busy); else pass_cnt++;
      total++; if (locked !== 4'hF) $display("FAIL ignore_locked_hold: got %h want f", locked); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      int lat;
      bit to;
      clear_cfg();
      init_off[3] = 3;
      clr = 1;
      @(negedge clk); #1;
      clr = 0;
      @(posedge clk); #1;
      realign = 1;
      @(posedge clk); #1;
      realign = 0;
      for (int i = 0; i < 5000 && !bitslip[3]; i++) begin
         @(negedge clk); #1;
      end
      total++; if (bitslip[3] !== 1'b1) $display("FAIL rstmid_reach_slip: got %b want 1", bitslip[3]); else pass_cnt++;
      rst = 1;
      #1;
      total++; if ({bitslip, realigned, busy, locked, fail} !== '0)
         $display("FAIL rstmid_outputs: got %h want 0", {bitslip, realigned, busy, locked, fail}); else pass_cnt++;
      repeat (5) @(negedge clk);
      @(posedge clk); #1;
      rst = 0;
      repeat (200) @(negedge clk);
      #1;
      total++; if (rl_cnt != 0) $display("FAIL rstmid_no_pulse: got %0d want 0", rl_cnt); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else pass_cnt++;
      run_seq(lat, to);
      total++; if (to) $display("FAIL rstmid_rerun_timeout: got no realigned_o want one"); else pass_cnt++;
      total++; if (slips_seen[3] != 3) $display("FAIL rstmid_rerun_slips: got %0d want 3", slips_seen[3]); else pass_cnt++;
      total++; if (locked !== 4'hF) $display("FAIL rstmid_rerun_locked: got %h want f", locked); else pass_cnt++;
      total++; if (lat != exp_lat()) $display("FAIL rstmid_rerun_latency: got %0d want %0d", lat, exp_lat()); else pass_cnt++;
   endtask

   task automatic test_random();
      int lat;
      bit to;
      logic ef;
      for (int k = 0; k < 6; k++) begin
         ef = 0;
         for (int n = 0; n < NCH; n++) begin
            init_off[n] = $urandom_range(0, W - 1);
            dead[n] = $urandom_range(0, 3) == 0;
            ef = ef | dead[n];
         end
         run_seq(lat, to);
         total++; if (to) $display("FAIL rnd%0d_timeout: got no realigned_o want one", k); else pass_cnt++;
         total++; if (lat != exp_lat()) $display("FAIL rnd%0d_latency: got %0d want %0d", k, lat, exp_lat()); else pass_cnt++;
         for (int n = 0; n < NCH; n++) begin
            total++; if (slips_seen[n] != exp_slips(n)) $display("FAIL rnd%0d_slips%0d: got %0d want %0d", k, n, slips_seen[n], exp_slips(n)); else pass_cnt++;
         end
         total++; if (locked !== exp_locked()) $display("FAIL rnd%0d_locked: got %h want %h", k, locked, exp_locked()); else pass_cnt++;
         total++; if (fail !== ef) $display("FAIL rnd%0d_fail: got %b want %b", k, fail, ef); else pass_cnt++;
         total++; if (rl_cnt != 1) $display("FAIL rnd%0d_pulses: got %0d want 1", k, rl_cnt); else pass_cnt++;
         total++; if (busy_low != 0) $display("FAIL rnd%0d_busy_gap: got %0d want 0", k, busy_low); else pass_cnt++;
         total++; if (multi != 0) $display("FAIL rnd%0d_onehot: got %0d multi-strobe cycles want 0", k, multi); else pass_cnt++;
         total++; if (min_gap < S + 1) $display("FAIL rnd%0d_gap: got %0d want >= %0d", k, min_gap, S + 1); else pass_cnt++;
      end
   endtask

`ifdef GLITC_REALIGN_ERRCNT_EN
   task automatic test_errcnt();
      int lat;
      bit to;
      clear_cfg();
      run_seq(lat, to);
      total++; if (err_count !== 16'd0) $display("FAIL err_after_lock: got %0d want 0", err_count); else pass_cnt++;
      @(posedge clk); #1;
      corrupt = 1;
      repeat (5) @(posedge clk);
      #1;
      corrupt = 0;
      @(negedge clk); #1;
      total++; if (err_count !== 16'd5) $display("FAIL err_five: got %0d want 5", err_count); else pass_cnt++;
      @(posedge clk); #1;
      err_clear = 1;
      @(posedge clk); #1;
      err_clear = 0;
      total++; if (err_count !== 16'd0) $display("FAIL err_clear: got %0d want 0", err_count); else pass_cnt++;
      corrupt = 1;
      repeat (70000) @(posedge clk);
      #1;
      corrupt = 0;
      total++; if (err_count !== 16'hFFFF) $display("FAIL err_saturate: got %h want ffff", err_count); else pass_cnt++;
   endtask
`endif

   initial begin
      test_reset();
      test_aligned();
      test_rotated();
      test_dead();
      test_ignore();
      test_reset_mid();
      test_random();
`ifdef GLITC_REALIGN_ERRCNT_EN
      test_errcnt();
`endif
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
